// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with single-line refill.
// The fetch result (valid) is combinational. inst and inst_pc are registered,
// so a fetch takes one cycle. Misses request one line from memory, which
// returns the line as LINE_WORDS beats in ascending word order.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | serving hits; a miss latches the line address and moves to REQ
//   REQ   | mem_req_valid high with a stable address, waiting for ready
//   FILL  | collecting refill beats; the final beat validates the line
module icache_dm #(
    parameter int          NUM_LINES  = 64,
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] RESET_PC   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipeline_en,
    input  logic        flush,
    input  logic [31:0] pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] miss_count
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int AW = WB + IB;              // word address inside the data array
    localparam int TW = 30 - AW;              // tag width
    localparam int BW = (WB > 0) ? WB : 1;    // beat counter width
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid_bits;
    logic [31:0]          lat_addr;
    logic [BW-1:0]        beat;
    logic                 flush_pend;

    logic [TW-1:0]        tag_mem  [0:NUM_LINES-1];
    logic [31:0]          data_mem [0:NUM_LINES*LINE_WORDS-1];

    logic [AW-1:0]        rd_addr;
    logic [IB-1:0]        rd_idx;
    logic [TW-1:0]        rd_tag;
    logic                 hit;
    logic [IB-1:0]        lat_idx;
    logic [TW-1:0]        lat_tag;
    logic [AW-1:0]        wr_addr;
    logic                 final_beat;

    assign rd_addr = pc[AW+1:2];
    assign rd_idx  = pc[AW+1:WB+2];
    assign rd_tag  = pc[31:AW+2];
    assign hit     = valid_bits[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign valid   = (state == IDLE) && !flush && hit;

    // lat_addr is line aligned, so OR-ing the beat number selects the word
    assign lat_idx    = lat_addr[AW+1:WB+2];
    assign lat_tag    = lat_addr[31:AW+2];
    assign wr_addr    = lat_addr[AW+1:2] | AW'(beat);
    assign final_beat = (beat == BW'(LINE_WORDS - 1));

    assign mem_req_addr = lat_addr;

    // Control FSM, fetch output registers and miss counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            valid_bits    <= '0;
            inst          <= 32'h0000_0013;
            inst_pc       <= RESET_PC;
            miss_count    <= '0;
            beat          <= '0;
            flush_pend    <= 1'b0;
            mem_req_valid <= 1'b0;
            lat_addr      <= '0;
        end else begin
            if (pipeline_en && valid) begin
                inst    <= data_mem[rd_addr];
                inst_pc <= pc;
            end
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid_bits <= '0;
                    end else if (!hit) begin
                        lat_addr      <= pc & ~LINE_MASK;
                        miss_count    <= miss_count + 32'd1;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat          <= '0;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_resp_valid) begin
                        beat <= beat + BW'(1);
                        if (final_beat) begin
                            // A flush seen during the refill leaves the cache empty
                            if (flush_pend || flush) valid_bits <= '0;
                            else                     valid_bits[lat_idx] <= 1'b1;
                            flush_pend <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage is not reset; valid_bits alone guards its contents
    always_ff @(posedge clk) begin
        if (state == FILL && mem_resp_valid) begin
            data_mem[wr_addr] <= mem_resp_data;
            if (final_beat) tag_mem[lat_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: vector table plus refill sequences,
// with a scoreboard of expected fetch results.
module tb_icache_dm;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipeline_en;
    logic        flush;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [31:0] miss_count;

    icache_dm #(.NUM_LINES(64), .LINE_WORDS(4), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pipeline_en(pipeline_en), .flush(flush),
        .pc(pc), .valid(valid), .inst(inst), .inst_pc(inst_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic        fl;
        logic        exp_valid;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[8];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_inst;
    logic [31:0] exp_inst_pc;
    logic [31:0] exp_miss;

    // Backing memory contents: line 0x8000_0000 holds 0x11,0x22,0x33,0x44
    function automatic logic [31:0] mw(input logic [31:0] a);
        if (a[31:4] == 28'h800_0000) return 32'h11 * ({30'b0, a[3:2]} + 32'd1);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE-state fetch: check the hit flag, then the registered outputs
    task automatic fetch(input logic [31:0] a, input logic en, input logic fl,
                         input logic exp_valid);
        exp_t e;
        bit   pushed;
        pushed      = 0;
        pc          = a;
        pipeline_en = en;
        flush       = fl;
        #1;
        chk("valid", {31'b0, valid}, {31'b0, exp_valid});
        if (en && exp_valid && !fl) begin
            e.inst = mw(a & ~32'h3);
            e.pc   = a;
            sb.push_back(e);
            pushed = 1;
        end
        if (!exp_valid && !fl) exp_miss = exp_miss + 32'd1;
        tick();
        flush = 1'b0;
        if (pushed) begin
            e           = sb.pop_front();
            exp_inst    = e.inst;
            exp_inst_pc = e.pc;
        end
        chk("inst", inst, exp_inst);
        chk("inst_pc", inst_pc, exp_inst_pc);
        chk("miss_count", miss_count, exp_miss);
    endtask

    // Serve one line refill; junk beats during REQ must be ignored
    task automatic refill(input logic [31:0] line, input int ready_delay,
                          input int gap_beat, input int flush_beat);
        for (int i = 0; i < 20 && !mem_req_valid; i++) tick();
        chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("req_addr", mem_req_addr, line);
        for (int d = 0; d < ready_delay; d++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_BEEF;
            tick();
            chk("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
            chk("req_hold_addr", mem_req_addr, line);
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("req_drop", {31'b0, mem_req_valid}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            if (b == gap_beat) begin
                mem_resp_valid = 1'b0;
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = mw(line + 32'(4 * b));
            flush          = (b == flush_beat);
            #1;
            chk("valid_in_fill", {31'b0, valid}, 32'd0);
            tick();
            flush = 1'b0;
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h8000_0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h8000_0004, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h8000_0008, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{32'h8000_000C, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0004, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h8000_0004, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{32'h8000_0004, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{32'h8000_0000, 1'b1, 1'b1, 1'b0};

        rst_n          = 1'b0;
        pipeline_en    = 1'b0;
        flush          = 1'b0;
        pc             = 32'h8000_0000;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        exp_inst       = 32'h0000_0013;
        exp_inst_pc    = RESET_PC;
        exp_miss       = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, RESET_PC);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);

        // First miss, slow ready and a gap between beats
        fetch(32'h8000_0008, 1'b1, 1'b0, 1'b0);
        refill(32'h8000_0000, 2, 1, -1);
        fetch(32'h8000_0008, 1'b1, 1'b0, 1'b1);

        // Streaming hits, stalled decode, then flush with pipeline_en
        foreach (tbl[i]) fetch(tbl[i].pc, tbl[i].en, tbl[i].fl, tbl[i].exp_valid);

        // Flushed line re-misses
        fetch(32'h8000_0000, 1'b1, 1'b0, 1'b0);
        refill(32'h8000_0000, 0, -1, -1);
        fetch(32'h8000_0004, 1'b1, 1'b0, 1'b1);

        // Conflict on index 0 with a new tag, then back to the old one
        fetch(32'h8000_0400, 1'b1, 1'b0, 1'b0);
        refill(32'h8000_0400, 1, 2, -1);
        fetch(32'h8000_0404, 1'b1, 1'b0, 1'b1);
        fetch(32'h8000_0000, 1'b1, 1'b0, 1'b0);
        refill(32'h8000_0000, 0, 3, -1);
        fetch(32'h8000_000C, 1'b1, 1'b0, 1'b1);

        // Flush during the refill leaves the filled line invalid
        fetch(32'h8000_0400, 1'b1, 1'b0, 1'b0);
        refill(32'h8000_0400, 0, -1, 2);
        fetch(32'h8000_0400, 1'b1, 1'b0, 1'b0);
        refill(32'h8000_0400, 0, -1, -1);
        fetch(32'h8000_0408, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a refill
        fetch(32'h8000_0000, 1'b1, 1'b0, 1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hBAD0_0000 + 32'(b);
            tick();
        end
        mem_resp_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        chk("midrst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("midrst_inst", inst, 32'h0000_0013);
        chk("midrst_inst_pc", inst_pc, RESET_PC);
        chk("midrst_miss_count", miss_count, 32'd0);
        tick();
        rst_n       = 1'b1;
        exp_inst    = 32'h0000_0013;
        exp_inst_pc = RESET_PC;
        exp_miss    = '0;
        sb.delete();
        fetch(32'h8000_0400, 1'b1, 1'b0, 1'b0);
        refill(32'h8000_0400, 0, -1, -1);
        fetch(32'h8000_0404, 1'b1, 1'b0, 1'b1);
        fetch(32'h8000_0000, 1'b1, 1'b0, 1'b0);
        refill(32'h8000_0000, 0, -1, -1);
        fetch(32'h8000_0008, 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter NUM_LINES, 64, number of cache lines; power of two, >= 2.
REQ-002 Parameter LINE_WORDS, 4, 32-bit words per line; power of two, >= 1.
REQ-003 Parameter RESET_PC, 32'h8000_0000, reset value of inst_pc.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 pipeline_en  in  1  decode stage accepts a fetch this cycle.
REQ-007 flush  in  1  invalidate all lines (fence.i).
REQ-008 pc  in  32  fetch address; bits [1:0] ignored.
REQ-009 valid  out  1  combinational hit for pc this cycle.
REQ-010 inst  out  32  registered instruction for inst_pc.
REQ-011 inst_pc  out  32  registered address of inst.
REQ-012 mem_req_valid  out  1  line refill request.
REQ-013 mem_req_ready  in  1  memory accepts request.
REQ-014 mem_req_addr  out  32  line-aligned refill address.
REQ-015 mem_resp_valid  in  1  refill data beat valid.
REQ-016 mem_resp_data  in  32  refill data beat, ascending word order.
REQ-017 miss_count  out  32  number of misses since reset.

Function
REQ-018 Address split: word offset = pc[2+WB-1:2], index = next IB bits, tag = remaining upper bits; WB=log2(LINE_WORDS), IB=log2(NUM_LINES).
REQ-019 Storage: per line one valid bit, one tag, LINE_WORDS data words; data and tags not reset.
REQ-020 FSM states IDLE, REQ, FILL.
REQ-021 valid = 1 only when state==IDLE, flush==0, line[index] valid, tag matches.
REQ-022 Posedge with pipeline_en && valid: inst <= word[index][offset], inst_pc <= pc (one-cycle fetch latency); otherwise inst, inst_pc hold.
REQ-023 IDLE, flush==0, valid==0: latch pc line address, miss_count += 1 (wraps at 2^32), go REQ.
REQ-024 REQ: mem_req_valid=1, mem_req_addr = latched line address (low 2+WB bits zero), held stable until mem_req_ready; on valid&&ready go FILL, beat counter = 0.
REQ-025 mem_req_valid = 0 in IDLE and FILL.
REQ-026 FILL: each mem_resp_valid writes mem_resp_data to word[beat counter] of latched index, counter += 1; beats may arrive with gaps.
REQ-027 On final beat (counter == LINE_WORDS-1): write tag, set valid bit, go IDLE; line hits next cycle earliest.
REQ-028 mem_resp_valid outside FILL ignored.
REQ-029 pc changes during REQ/FILL do not abort the refill; valid stays 0 until IDLE.
REQ-030 flush in IDLE: all valid bits cleared at next edge; no miss started that cycle.
REQ-031 flush in REQ/FILL: latched as pending; refill completes normally but its line is not marked valid; all valid bits cleared on return to IDLE; pending cleared.
REQ-032 Simultaneous flush and pipeline_en: no inst update (valid==0).

Reset
REQ-033 rst_n low: state IDLE, all valid bits 0, inst = 32'h0000_0013 (NOP), inst_pc = RESET_PC, miss_count = 0, beat counter 0, flush pending 0, mem_req_valid 0.
REQ-034 Reset mid-REQ/FILL abandons the refill; partially written line stays invalid; memory side resets together.

Verification
V1 rst_n low then high, pc=0x8000_0000 -> valid=0, inst=0x0000_0013, inst_pc=0x8000_0000, mem_req_valid=0, miss_count=0.
V2 pc=0x8000_0008, mem_req_ready low 2 cycles -> mem_req_valid=1, addr=0x8000_0000 held; beats 0x11,0x22,0x33,0x44 with one gap -> valid=1 next cycle; with pipeline_en inst=0x33, inst_pc=0x8000_0008; miss_count=1.
V3 pc 0x8000_0000..0x8000_000C consecutive, pipeline_en=1 -> valid every cycle, inst 0x11,0x22,0x33,0x44 one cycle later, no mem_req_valid.
V4 pc=0x8000_0400 (index 0, new tag) refilled, then pc=0x8000_0000 -> misses again, second refill; miss_count=3.
V5 flush one cycle after V2 -> pc=0x8000_0000 misses; flush during FILL beat 2 -> line invalid after fill, re-miss.
V6 hit with pipeline_en=0 three cycles -> inst, inst_pc unchanged; rst_n low after 2 FILL beats -> IDLE, same pc misses again.
